// File: rtl/tilemap_layer.sv
// rtl/tilemap_layer.sv - 8x8 tile background layer with one-tile-ahead GFX prefetch
module tilemap_layer #(
    parameter int MAP_W_LOG2 = 7,
    parameter int MAP_H_LOG2 = 7,
    parameter int BPP        = 4,
    parameter int TILE_BITS  = 10,
    parameter int PAL_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ce_pixel,
    input  logic [1:0]              wr,
    input  logic                    cs_ram,
    input  logic                    cs_reg,
    input  logic [15:0]             address,
    input  logic [15:0]             din,
    output logic [15:0]             dout,
    input  logic [11:0]             hcnt,
    input  logic [11:0]             vcnt,
    output logic [TILE_BITS+2:0]    gfx_addr,
    output logic                    gfx_req,
    input  logic                    gfx_ack,
    input  logic [8*BPP-1:0]        gfx_data,
    output logic [PAL_BITS+BPP-1:0] color_out,
    output logic                    opaque
);
    localparam int AW = MAP_W_LOG2 + MAP_H_LOG2;
    localparam int RW = 8 * BPP;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MAP_RD = 2'd1;
    localparam logic [1:0] S_MAP_WT = 2'd2;
    localparam logic [1:0] S_GFX    = 2'd3;

    logic [15:0]             r_map [0:(1<<AW)-1];
    logic [15:0]             r_ram_a, r_ram_b;
    logic [15:0]             r_hofs, r_vofs;
    logic                    r_enable, r_underrun;
    logic [1:0]              r_state;
    logic [AW-1:0]           r_fetch_addr;
    logic [2:0]              r_fetch_row;
    logic [TILE_BITS+2:0]    r_gfx_addr;
    logic                    r_gfx_req;
    logic [PAL_BITS-1:0]     r_ent_pal, r_stg_pal, r_pal;
    logic                    r_ent_flipx, r_stg_flipx, r_stg_valid, r_discard;
    logic [RW-1:0]           r_stg_data, r_shift;
    logic [PAL_BITS+BPP-1:0] r_color;
    logic                    r_opaque;
    logic [11:0]             r_vcnt_prev;

    logic [11:0]             w_h, w_v, w_f;
    logic [AW-1:0]           w_map_addr;
    logic [BPP-1:0]          w_pen;
    logic [RW-1:0]           w_stg_rev;
    logic [15:0]             w_reg_rd;
    logic                    w_status_clr;
    logic                    w_unused;

    assign w_h          = hcnt + r_hofs[11:0];
    assign w_v          = vcnt + r_vofs[11:0];
    assign w_f          = w_h + 12'd8;
    assign w_map_addr   = {w_v[MAP_H_LOG2+2:3], w_f[MAP_W_LOG2+2:3]};
    assign w_pen        = r_shift[RW-1 -: BPP];
    assign w_status_clr = cs_reg && (address[1:0] == 2'd3) && wr[0] && din[0];
    assign w_unused     = ^{address, w_v, w_f, r_ram_b};

    always_comb begin
        w_stg_rev = '0;
        for (int i = 0; i < 8; i++)
            w_stg_rev[i*BPP +: BPP] = r_stg_data[(7-i)*BPP +: BPP];
    end

    // Port A: CPU read/write with byte lanes; port B: read-only video side
    always_ff @(posedge clk) begin
        if (cs_ram && wr[0]) r_map[address[AW-1:0]][7:0]  <= din[7:0];
        if (cs_ram && wr[1]) r_map[address[AW-1:0]][15:8] <= din[15:8];
        r_ram_a <= r_map[address[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        r_ram_b <= r_map[r_fetch_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hofs   <= '0;
            r_vofs   <= '0;
            r_enable <= 1'b0;
        end else if (cs_reg) begin
            case (address[1:0])
                2'd0: begin
                    if (wr[0]) r_hofs[7:0]  <= din[7:0];
                    if (wr[1]) r_hofs[15:8] <= din[15:8];
                end
                2'd1: begin
                    if (wr[0]) r_vofs[7:0]  <= din[7:0];
                    if (wr[1]) r_vofs[15:8] <= din[15:8];
                end
                2'd2:    if (wr[0]) r_enable <= din[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        case (address[1:0])
            2'd0:    w_reg_rd = r_hofs;
            2'd1:    w_reg_rd = r_vofs;
            2'd2:    w_reg_rd = {15'd0, r_enable};
            default: w_reg_rd = {15'd0, r_underrun};
        endcase
    end

    assign dout = cs_reg ? w_reg_rd : r_ram_a;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_fetch_addr <= '0;
            r_fetch_row  <= '0;
            r_gfx_addr   <= '0;
            r_gfx_req    <= 1'b0;
            r_ent_pal    <= '0;
            r_ent_flipx  <= 1'b0;
            r_stg_data   <= '0;
            r_stg_pal    <= '0;
            r_stg_flipx  <= 1'b0;
            r_stg_valid  <= 1'b0;
            r_discard    <= 1'b0;
            r_shift      <= '0;
            r_pal        <= '0;
            r_color      <= '0;
            r_opaque     <= 1'b0;
            r_vcnt_prev  <= '0;
            r_underrun   <= 1'b0;
        end else begin
            if (w_status_clr) r_underrun <= 1'b0;

            // Pixel pipeline; the load consumes staging before any same-clock ack refills it
            if (ce_pixel) begin
                r_color  <= r_enable ? {r_pal, w_pen} : '0;
                r_opaque <= r_enable && (w_pen != '0);
                if (w_h[2:0] == 3'd7) begin
                    if (r_stg_valid) begin
                        r_shift     <= r_stg_flipx ? w_stg_rev : r_stg_data;
                        r_pal       <= r_stg_pal;
                        r_stg_valid <= 1'b0;
                    end else begin
                        r_shift    <= '0;
                        r_pal      <= '0;
                        r_underrun <= 1'b1;
                    end
                end else begin
                    r_shift <= r_shift << BPP;
                end
            end

            case (r_state)
                S_IDLE: if (ce_pixel && w_f[2:0] == 3'd0) begin
                    r_state      <= S_MAP_RD;
                    r_fetch_addr <= w_map_addr;
                    r_fetch_row  <= w_v[2:0];
                    r_discard    <= 1'b0;
                end
                S_MAP_RD: r_state <= S_MAP_WT;
                S_MAP_WT: begin
                    r_state     <= S_GFX;
                    r_gfx_req   <= 1'b1;
                    r_gfx_addr  <= {r_ram_b[TILE_BITS-1:0],
                                    r_ram_b[TILE_BITS+1] ? ~r_fetch_row : r_fetch_row};
                    r_ent_pal   <= r_ram_b[15 -: PAL_BITS];
                    r_ent_flipx <= r_ram_b[TILE_BITS];
                end
                default: if (gfx_ack) begin
                    r_state   <= S_IDLE;
                    r_gfx_req <= 1'b0;
                    if (!r_discard) begin
                        r_stg_data  <= gfx_data;
                        r_stg_pal   <= r_ent_pal;
                        r_stg_flipx <= r_ent_flipx;
                        r_stg_valid <= 1'b1;
                    end
                end
            endcase

            // A new line invalidates staged data and any fetch already under way
            if (ce_pixel) begin
                r_vcnt_prev <= vcnt;
                if (vcnt != r_vcnt_prev) begin
                    r_stg_valid <= 1'b0;
                    if (r_state != S_IDLE) r_discard <= 1'b1;
                end
            end
        end
    end

    assign gfx_addr  = r_gfx_addr;
    assign gfx_req   = r_gfx_req;
    assign color_out = r_color;
    assign opaque    = r_opaque;

endmodule
